// File: rtl/sid_bus_pkg.sv
// sid_bus_pkg: shared definitions for the SID write path.
//   - Field positions of the 2-byte SPI write protocol:
//       header 1AAA AADD  (address, data[7:6])
//       data   0?DD DDDD  (data[5:0])
//   - sid_wr_t: one queued SID register write {addr, data}.
//   - Helpers that classify a protocol byte and assemble a write entry.
package sid_bus_pkg;

    localparam int SID_ADDR_W = 5;
    localparam int SID_DATA_W = 8;

    localparam int HDR_BIT    = 7;
    localparam int ADDR_MSB   = 6;
    localparam int ADDR_LSB   = 2;
    localparam int HI_MSB     = 1;
    localparam int HI_LSB     = 0;
    localparam int LO_MSB     = 5;
    localparam int LO_LSB     = 0;

    typedef struct packed {
        logic [SID_ADDR_W-1:0] addr;
        logic [SID_DATA_W-1:0] data;
    } sid_wr_t;

    // True when the byte is a header (address + top two data bits).
    function automatic logic is_header(input logic [7:0] b);
        return b[HDR_BIT];
    endfunction

    // Build a write entry from the latched header fields and a data byte.
    // Bit 6 of the data byte carries no information and is dropped here.
    function automatic sid_wr_t make_wr(input logic [SID_ADDR_W-1:0] addr,
                                        input logic [1:0]            hi,
                                        input logic [7:0]            b);
        sid_wr_t w;
        w.addr = addr;
        w.data = {hi, b[LO_MSB:LO_LSB]};
        return w;
    endfunction

endpackage

// File: rtl/sid_wr_fifo.sv
// sid_wr_fifo: synchronous FIFO of sid_wr_t entries.
//   clk, rst  : clock, asynchronous active-high reset (empties the FIFO)
//   push, din : enqueue din; accepted when not full, or when full and a pop
//               happens in the same cycle
//   pop, dout : dequeue; dout always shows the head entry
//   full/empty: occupancy flags derived from the explicit level counter
//   level     : registered occupancy, 0..DEPTH
module sid_wr_fifo
    import sid_bus_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  sid_wr_t          din,
    output sid_wr_t          dout,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    sid_wr_t          mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify requests: a full FIFO still accepts a push when it pops in the same cycle.
    always_comb begin
        pop_ok_s  = 1'b0;
        push_ok_s = 1'b0;
        if (pop && (level_r != LVL_W'(0))) begin
            pop_ok_s = 1'b1;
        end else begin
            pop_ok_s = 1'b0;
        end
        if (push && ((level_r != LVL_W'(DEPTH)) || pop_ok_s)) begin
            push_ok_s = 1'b1;
        end else begin
            push_ok_s = 1'b0;
        end
    end

    // Entry storage; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); level is tracked explicitly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            level_r  <= LVL_W'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = (level_r == LVL_W'(DEPTH));
    assign empty = (level_r == LVL_W'(0));
    assign level = level_r;

endmodule

// File: rtl/sid_bus_writer.sv
// sid_bus_writer: decodes SPI protocol bytes into SID register writes, queues
// them, and replays at most one write per 1 MHz SID enable.
//   clk, rst    : 12 MHz system clock, asynchronous active-high reset
//   iByte       : byte from the SPI slave, qualified by iByteValid
//   iClkEn      : 1 MHz SID enable pulse; a queued write pops on it
//   iClrOvf     : clears oOverflow (a simultaneous drop keeps it set)
//   oWE         : one-clk write strobe, the cycle after a pop
//   oAddr/oDataW: write address/data, held between writes
//   oLevel      : FIFO occupancy
//   oOverflow   : sticky, a write was dropped on a full FIFO
module sid_bus_writer
    import sid_bus_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = SID_ADDR_W,
    parameter int DATA_W     = SID_DATA_W,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        iByte,
    input  logic              iByteValid,
    input  logic              iClkEn,
    input  logic              iClrOvf,
    output logic              oWE,
    output logic [ADDR_W-1:0] oAddr,
    output logic [DATA_W-1:0] oDataW,
    output logic [LVL_W-1:0]  oLevel,
    output logic              oOverflow
);

    logic [SID_ADDR_W-1:0] hdr_addr_r;
    logic [1:0]            hdr_hi_r;
    logic                  push_s;
    logic                  pop_s;
    logic                  drop_s;
    logic                  full_s;
    logic                  empty_s;
    sid_wr_t               din_s;
    sid_wr_t               head_s;

    // Byte decode and FIFO handshake; a push into an empty FIFO cannot pop the same cycle.
    always_comb begin
        push_s = 1'b0;
        pop_s  = 1'b0;
        drop_s = 1'b0;
        din_s  = make_wr(hdr_addr_r, hdr_hi_r, iByte);
        if (iByteValid && !is_header(iByte)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        if (iClkEn && !empty_s) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        if (push_s && full_s && !pop_s) begin
            drop_s = 1'b1;
        end else begin
            drop_s = 1'b0;
        end
    end

    // Header latch; persists so repeated data bytes stream to the same register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_addr_r <= SID_ADDR_W'(0);
            hdr_hi_r   <= 2'b00;
        end else if (iByteValid && is_header(iByte)) begin
            hdr_addr_r <= iByte[ADDR_MSB:ADDR_LSB];
            hdr_hi_r   <= iByte[HI_MSB:HI_LSB];
        end
    end

    sid_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (din_s),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s),
        .level (oLevel)
    );

    // Write issue: capture the head on a pop, strobe oWE for the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oWE    <= 1'b0;
            oAddr  <= ADDR_W'(0);
            oDataW <= DATA_W'(0);
        end else begin
            oWE <= pop_s;
            if (pop_s) begin
                oAddr  <= head_s.addr;
                oDataW <= head_s.data;
            end
        end
    end

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oOverflow <= 1'b0;
        end else if (drop_s) begin
            oOverflow <= 1'b1;
        end else if (iClrOvf) begin
            oOverflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sid_bus_writer.sv
// Scoreboard bench for sid_bus_writer. A reference model (queues + arithmetic)
// predicts every write and its cycle; a monitor compares at each negedge.
module tb_sid_bus_writer;

    localparam int DEPTH = 16;
    localparam int LVL_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       iByte;
    logic             iByteValid;
    logic             iClkEn;
    logic             iClrOvf;
    logic             oWE;
    logic [4:0]       oAddr;
    logic [7:0]       oDataW;
    logic [LVL_W-1:0] oLevel;
    logic             oOverflow;

    sid_bus_writer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .iByte(iByte), .iByteValid(iByteValid),
        .iClkEn(iClkEn), .iClrOvf(iClrOvf), .oWE(oWE), .oAddr(oAddr),
        .oDataW(oDataW), .oLevel(oLevel), .oOverflow(oOverflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int addr; int data; int due; } exp_t;
    int   mq_addr[$];
    int   mq_data[$];
    exp_t expq[$];
    int   m_ovf = 0;
    int   h_addr = 0;
    int   h_hi = 0;
    int   cyc = 0;
    int   m_pre;
    bit   m_pop;
    bit   m_drop;
    exp_t m_e;

    // Each edge: pop first (judged on occupancy before the push), then push or drop.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                mq_addr.delete();
                mq_data.delete();
                m_ovf  = 0;
                h_addr = 0;
                h_hi   = 0;
            end else begin
                m_pre  = mq_addr.size();
                m_pop  = iClkEn && (m_pre > 0);
                m_drop = 0;
                if (m_pop) begin
                    m_e.addr = mq_addr.pop_front();
                    m_e.data = mq_data.pop_front();
                    m_e.due  = cyc;
                    expq.push_back(m_e);
                end
                if (iByteValid && iByte < 128) begin
                    if (m_pre < DEPTH || m_pop) begin
                        mq_addr.push_back(h_addr);
                        mq_data.push_back(h_hi * 64 + iByte % 64);
                    end else begin
                        m_drop = 1;
                    end
                end
                if (m_drop) m_ovf = 1;
                else if (iClrOvf) m_ovf = 0;
                if (iByteValid && iByte >= 128) begin
                    h_addr = (iByte / 4) % 32;
                    h_hi   = iByte % 4;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    int wr_count = 0;
    int last_addr, last_data, last_cyc;
    int mon_exp_we;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                expq.delete();
            end else begin
                check("level", int'(oLevel), mq_addr.size());
                check("overflow", int'(oOverflow), m_ovf);
                mon_exp_we = (expq.size() > 0 && expq[0].due == cyc) ? 1 : 0;
                check("we", int'(oWE), mon_exp_we);
                if (oWE) begin
                    wr_count++;
                    last_addr = int'(oAddr);
                    last_data = int'(oDataW);
                    last_cyc  = cyc;
                end
                if (mon_exp_we == 1) begin
                    if (oWE) begin
                        check("wr_addr", int'(oAddr), expq[0].addr);
                        check("wr_data", int'(oDataW), expq[0].data);
                    end
                    void'(expq.pop_front());
                end
            end
        end
    end

    // ---------------- iClkEn generator ----------------
    bit en_gen = 1;
    int ph = 0;

    initial begin
        iClkEn = 1'b0;
        forever begin
            @(negedge clk);
            if (en_gen) begin
                ph = (ph == 11) ? 0 : ph + 1;
                iClkEn = (ph == 0);
            end else begin
                iClkEn = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int last_push_edge = 0;

    task automatic next_cycle();
        @(negedge clk);
        #1;
        iByteValid = 1'b0;
        iByte      = 8'h00;
        iClrOvf    = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        next_cycle();
        iByteValid     = 1'b1;
        iByte          = b;
        last_push_edge = cyc + 1;
    endtask

    task automatic clr_ovf();
        next_cycle();
        iClrOvf = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) next_cycle();
    endtask

    // Leaves the caller inside a cycle whose upcoming edge carries iClkEn.
    task automatic align_en();
        int k = 0;
        next_cycle();
        while (!iClkEn && k < 30) begin
            next_cycle();
            k++;
        end
        if (!iClkEn) check("align_timeout", int'(iClkEn), 1);
    endtask

    task automatic wait_wr(input int target, input int budget);
        int k = 0;
        while (wr_count < target && k < budget) begin
            next_cycle();
            k++;
        end
        if (wr_count < target) check("wr_timeout", wr_count, target);
    endtask

    task automatic drain();
        int k = 0;
        en_gen = 1;
        while ((mq_addr.size() > 0 || expq.size() > 0) && k < DEPTH * 12 + 40) begin
            next_cycle();
            k++;
        end
        if (mq_addr.size() > 0) check("drain_timeout", mq_addr.size(), 0);
        idle(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    int start, c1, c2, c3, r;

    initial begin
        rst = 1'b1; iByte = 8'h00; iByteValid = 1'b0; iClrOvf = 1'b0;
        #1;
        check("rst_we", int'(oWE), 0);
        check("rst_addr", int'(oAddr), 0);
        check("rst_data", int'(oDataW), 0);
        check("rst_level", int'(oLevel), 0);
        check("rst_ovf", int'(oOverflow), 0);
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;

        // 1: header addr 1 hi=10, data lo 0x15 -> addr 1 data 0x95
        drain();
        start = wr_count;
        send(8'h86);
        send(8'h15);
        wait_wr(start + 1, 40);
        check("t1_addr", last_addr, 1);
        check("t1_data", last_data, 8'h95);
        check("t1_latency_in_range",
              ((last_cyc - last_push_edge) >= 1 && (last_cyc - last_push_edge) <= 12) ? 1 : 0, 1);

        // 2: header 0xE0 -> addr 0x18, three data writes 12 clks apart
        drain();
        start = wr_count;
        send(8'hE0); send(8'h01); send(8'h02); send(8'h03);
        wait_wr(start + 1, 40); c1 = last_cyc; check("t2_addr", last_addr, 8'h18); check("t2_d1", last_data, 1);
        wait_wr(start + 2, 40); c2 = last_cyc; check("t2_d2", last_data, 2);
        wait_wr(start + 3, 40); c3 = last_cyc; check("t2_d3", last_data, 3);
        check("t2_gap1", c2 - c1, 12);
        check("t2_gap2", c3 - c2, 12);

        // 3: DEPTH+2 data bytes with no enable -> full, overflow, DEPTH writes drain
        drain();
        en_gen = 0;
        clr_ovf();
        for (int i = 0; i < DEPTH + 2; i++) send(8'(i));
        next_cycle();
        check("t3_level", int'(oLevel), DEPTH);
        check("t3_ovf", int'(oOverflow), 1);
        start = wr_count;
        en_gen = 1;
        wait_wr(start + DEPTH, DEPTH * 12 + 30);
        idle(30);
        check("t3_drained", wr_count - start, DEPTH);

        // 4: full FIFO, push coincident with pop -> level stays DEPTH, no overflow
        drain();
        en_gen = 0;
        clr_ovf();
        for (int i = 0; i < DEPTH; i++) send(8'(i + 32));
        next_cycle();
        check("t4_full", int'(oLevel), DEPTH);
        check("t4_ovf_clr", int'(oOverflow), 0);
        en_gen = 1;
        align_en();
        iByteValid = 1'b1;
        iByte      = 8'h2A;
        next_cycle();
        check("t4_level", int'(oLevel), DEPTH);
        check("t4_ovf", int'(oOverflow), 0);

        // 5: empty FIFO, push on an enable cycle -> pops on the next enable
        drain();
        start = wr_count;
        align_en();
        iByteValid     = 1'b1;
        iByte          = 8'h11;
        last_push_edge = cyc + 1;
        wait_wr(start + 1, 40);
        check("t5_latency", last_cyc - last_push_edge, 12);

        // 6: reset with entries queued while a write strobe is live
        drain();
        en_gen = 0;
        send(8'h84);
        for (int i = 0; i < 5; i++) send(8'(i + 5));
        en_gen = 1;
        align_en();
        @(posedge clk);
        #2;
        check("t6_we_live", int'(oWE), 1);
        rst = 1'b1;
        #1;
        check("t6_level", int'(oLevel), 0);
        check("t6_we", int'(oWE), 0);
        idle(2);
        rst = 1'b0;
        start = wr_count;
        send(8'h3F);
        wait_wr(start + 1, 40);
        check("t6_addr", last_addr, 0);
        check("t6_data", last_data, 8'h3F);

        // Random traffic: bursty and sparse phases, enable pauses, overflow clears
        drain();
        for (int i = 0; i < 1200; i++) begin
            next_cycle();
            if (i % 150 == 0) en_gen = ($urandom_range(0, 2) != 0);
            r = $urandom_range(0, 99);
            if (r < ((i / 200) % 2 == 0 ? 45 : 6)) begin
                iByteValid = 1'b1;
                iByte      = 8'($urandom_range(0, 127));
            end else if (r < 55) begin
                iByteValid = 1'b1;
                iByte      = 8'($urandom_range(128, 255));
            end
            if ($urandom_range(0, 99) < 4) iClrOvf = 1'b1;
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
